// File: rtl/reg_bank_wb_if.sv
// reg_bank_wb_if: register-file bus bundle between the multicycle datapath
// and reg_bank_wb.
//   Write port : reg_write, write_reg, write_data   (datapath -> bank)
//   Read ports : read_reg_a/b -> read_data_a/b      (combinational)
//   Commit rec : wb_valid, wb_reg, wb_data          (registered, bank -> datapath)
// master modport = datapath side, slave modport = register bank side.
interface reg_bank_wb_if #(
  parameter int unsigned DATA_W = 32
);
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [4:0]        read_reg_a;
  logic [4:0]        read_reg_b;
  logic [DATA_W-1:0] read_data_a;
  logic [DATA_W-1:0] read_data_b;
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output reg_write, write_reg, write_data, read_reg_a, read_reg_b,
    input  read_data_a, read_data_b, wb_valid, wb_reg, wb_data
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg_a, read_reg_b,
    output read_data_a, read_data_b, wb_valid, wb_reg, wb_data
  );
endinterface

// File: rtl/reg_bank_wb.sv
// reg_bank_wb: 32 x DATA_W MIPS general-purpose register file.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-high reset (regs -> 0, $sp -> SP_INIT)
//   bus   : reg_bank_wb_if.slave
//           - one synchronous write port (reg_write/write_reg/write_data)
//           - two combinational read ports (read_reg_a/b -> read_data_a/b)
//           - one-cycle commit record (wb_valid/wb_reg/wb_data)
// Register 0 has no storage and always reads 0.
// Optional build macro REG_BANK_WB_BYPASS_EN: read ports forward write_data
// when they address the register being written in the same cycle.
module reg_bank_wb #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 227,
  parameter int unsigned       SP_IDX  = 29
) (
  input  logic          clk,
  input  logic          reset,
  reg_bank_wb_if.slave  bus
);

  // Storage for registers 1..31 only; register 0 is a constant.
  logic [DATA_W-1:0] regs [1:31];
  logic              commit;

  // A write lands only when enabled, not in reset, and not aimed at $zero.
  assign commit = bus.reg_write && !reset && (bus.write_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      bus.wb_valid <= 1'b0;
      bus.wb_reg   <= '0;
      bus.wb_data  <= '0;
    end else begin
      bus.wb_valid <= commit;
      if (commit) begin
        regs[bus.write_reg] <= bus.write_data;
        bus.wb_reg          <= bus.write_reg;
        bus.wb_data         <= bus.write_data;
      end
    end
  end

  always_comb begin
    bus.read_data_a = '0;
    if (bus.read_reg_a != 5'd0) begin
`ifdef REG_BANK_WB_BYPASS_EN
      if (commit && (bus.read_reg_a == bus.write_reg)) begin
        bus.read_data_a = bus.write_data;
      end else begin
        bus.read_data_a = regs[bus.read_reg_a];
      end
`else
      bus.read_data_a = regs[bus.read_reg_a];
`endif
    end
  end

  always_comb begin
    bus.read_data_b = '0;
    if (bus.read_reg_b != 5'd0) begin
`ifdef REG_BANK_WB_BYPASS_EN
      if (commit && (bus.read_reg_b == bus.write_reg)) begin
        bus.read_data_b = bus.write_data;
      end else begin
        bus.read_data_b = regs[bus.read_reg_b];
      end
`else
      bus.read_data_b = regs[bus.read_reg_b];
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank_wb.sv
// tb_reg_bank_wb: directed self-checking bench for reg_bank_wb.
// Inputs change 1 ns after a rising edge; outputs are checked before the
// next rising edge. Build with REG_BANK_WB_BYPASS_EN to exercise forwarding.
module tb_reg_bank_wb;

  localparam int unsigned DATA_W = 32;

  logic clk;
  logic reset;

  reg_bank_wb_if #(.DATA_W(DATA_W)) bus ();

  reg_bank_wb #(
    .DATA_W (DATA_W),
    .SP_INIT(32'd227),
    .SP_IDX (29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic en, input logic [4:0] idx, input logic [31:0] data);
    bus.reg_write  = en;
    bus.write_reg  = idx;
    bus.write_data = data;
  endtask

  initial begin
    reset = 1'b1;
    set_write(1'b0, 5'd0, 32'h0);
    bus.read_reg_a = 5'd0;
    bus.read_reg_b = 5'd0;

    // Reset state
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.read_reg_a = 5'(i);
      #1;
      check($sformatf("reset_reg%0d", i), bus.read_data_a, (i == 29) ? 32'd227 : 32'd0);
    end
    check("reset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("reset_wb_reg",   {27'd0, bus.wb_reg},   32'd0);
    check("reset_wb_data",  bus.wb_data,           32'd0);

    // Single write to r8
    set_write(1'b1, 5'd8, 32'hDEADBEEF);
    bus.read_reg_a = 5'd8;
    #1;
`ifdef REG_BANK_WB_BYPASS_EN
    check("r8_same_cycle", bus.read_data_a, 32'hDEADBEEF);
`else
    check("r8_same_cycle", bus.read_data_a, 32'h0);
`endif
    step();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    check("r8_read",     bus.read_data_a,           32'hDEADBEEF);
    check("r8_wb_valid", {31'd0, bus.wb_valid},     32'd1);
    check("r8_wb_reg",   {27'd0, bus.wb_reg},       32'd8);
    check("r8_wb_data",  bus.wb_data,               32'hDEADBEEF);
    step();
    check("r8_wb_pulse_end", {31'd0, bus.wb_valid}, 32'd0);
    check("r8_wb_data_hold", bus.wb_data,           32'hDEADBEEF);

    // Write to r0 is discarded
    set_write(1'b1, 5'd0, 32'h12345678);
    bus.read_reg_a = 5'd0;
    bus.read_reg_b = 5'd0;
    #1;
    check("r0_same_a", bus.read_data_a, 32'h0);
    check("r0_same_b", bus.read_data_b, 32'h0);
    step();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    check("r0_read_a",   bus.read_data_a,       32'h0);
    check("r0_read_b",   bus.read_data_b,       32'h0);
    check("r0_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("r0_wb_reg",   {27'd0, bus.wb_reg},   32'd8);

    // Overwrite $sp, then reset together with a write to $sp
    set_write(1'b1, 5'd29, 32'h55);
    step();
    set_write(1'b0, 5'd0, 32'h0);
    bus.read_reg_a = 5'd29;
    #1;
    check("sp_written", bus.read_data_a, 32'h55);
    reset = 1'b1;
    set_write(1'b1, 5'd29, 32'd5);
    step();
    reset = 1'b0;
    set_write(1'b0, 5'd0, 32'h0);
    bus.read_reg_b = 5'd8;
    #1;
    check("rst_sp",       bus.read_data_a,       32'd227);
    check("rst_r8",       bus.read_data_b,       32'h0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_reg",   {27'd0, bus.wb_reg},   32'd0);
    check("rst_wb_data",  bus.wb_data,           32'd0);

    // Read-during-write on r31
    set_write(1'b1, 5'd31, 32'h10);
    step();
    set_write(1'b1, 5'd31, 32'h400);
    bus.read_reg_a = 5'd31;
    #1;
`ifdef REG_BANK_WB_BYPASS_EN
    check("r31_rdw", bus.read_data_a, 32'h400);
`else
    check("r31_rdw", bus.read_data_a, 32'h10);
`endif
    step();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    check("r31_after",   bus.read_data_a, 32'h400);
    check("r31_wb_data", bus.wb_data,     32'h400);

    // Back-to-back writes 3,4,3
    set_write(1'b1, 5'd3, 32'd1);
    step();
    check("b2b1_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("b2b1_reg",   {27'd0, bus.wb_reg},   32'd3);
    check("b2b1_data",  bus.wb_data,           32'd1);
    set_write(1'b1, 5'd4, 32'd2);
    step();
    check("b2b2_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("b2b2_reg",   {27'd0, bus.wb_reg},   32'd4);
    check("b2b2_data",  bus.wb_data,           32'd2);
    set_write(1'b1, 5'd3, 32'd3);
    step();
    set_write(1'b0, 5'd0, 32'h0);
    check("b2b3_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("b2b3_reg",   {27'd0, bus.wb_reg},   32'd3);
    check("b2b3_data",  bus.wb_data,           32'd3);
    bus.read_reg_a = 5'd3;
    bus.read_reg_b = 5'd4;
    #1;
    check("b2b_r3", bus.read_data_a, 32'd3);
    check("b2b_r4", bus.read_data_b, 32'd2);
    step();
    check("b2b_end_valid", {31'd0, bus.wb_valid}, 32'd0);

    // Both ports on the same register
    bus.read_reg_a = 5'd4;
    bus.read_reg_b = 5'd4;
    #1;
    check("same_idx_a", bus.read_data_a, 32'd2);
    check("same_idx_b", bus.read_data_b, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32 x 32-bit MIPS general-purpose register file; write-back destination of the multicycle datapath.
- Write address comes from the write-register select mux (rt / 29 / 31 / rd); write data comes from the write-back data mux.
- Two combinational read ports feed the A/B operand registers.
- One synchronous write port, plus a one-cycle write-commit record for debug and bench observation.

Parameters:
- DATA_W, 32, register width in bits.
- SP_INIT, 227, reset value of register 29 ($sp).
- SP_IDX, 29, index of the stack-pointer register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
- reg_write  input  1  write enable from control unit.
- write_reg  input  5  destination register index (output of write-register mux).
- write_data  input  DATA_W  data to write.
- read_reg_a  input  5  read port A index (instr[25:21]).
- read_reg_b  input  5  read port B index (instr[20:16]).
- read_data_a  output  DATA_W  contents of register read_reg_a, combinational.
- read_data_b  output  DATA_W  contents of register read_reg_b, combinational.
- wb_valid  output  1  registered pulse: a write committed on the previous edge.
- wb_reg  output  5  index committed on the previous edge.
- wb_data  output  DATA_W  value committed on the previous edge.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - reset is synchronous and active-high; no asynchronous reset path anywhere.
- Storage:
  - Registers 1..31 are flops.
  - Register 0 is hardwired to 0: no flop, never written, always reads 0.
- Reset (reset=1 at a rising edge):
  - All registers become 0, except register SP_IDX = SP_INIT (227).
  - wb_valid=0, wb_reg=0, wb_data=0.
  - reset has priority over reg_write in the same cycle; no write occurs.
- Write:
  - At a rising edge with reset=0, reg_write=1 and write_reg!=0: reg[write_reg] <= write_data.
  - If write_reg==0, the write is discarded. Register 0 stays 0, and wb_valid stays 0 on the next cycle.
  - reg_write=0: array unchanged.
  - Write data is X-free by contract. If reg_write=0, write_reg and write_data are don't-care.
- Commit record:
  - wb_valid <= reg_write & ~reset & (write_reg!=0).
  - wb_reg and wb_data are loaded only when that expression is 1; otherwise they hold their previous values.
  - wb_valid is a single-cycle pulse per committed write. Back-to-back writes give wb_valid high on consecutive cycles.
- Read:
  - Zero-latency combinational read of the current array state.
  - read_reg_x==0 returns 0.
  - Both ports may address the same register simultaneously; both return the same value.
- Read-during-write (bypass disabled):
  - A port reads the pre-edge value in the writing cycle.
  - The new value is visible from the cycle after the edge.
- Reset mid-operation:
  - A write pending in the reset cycle is lost.
  - Registers already written are overwritten with reset values.
- Registers 31 ($ra) and 29 ($sp) have no special write semantics beyond the SP reset value. Writes via the mux's constant 29/31 paths behave like any other index.

Optional Feature:
- Macro: REG_BANK_WB_BYPASS_EN.
- Defined:
  - Each read port compares its index with write_reg.
  - If reg_write=1, reset=0, write_reg!=0 and the indices match, the port outputs write_data combinationally in the same cycle (write-through forwarding).
  - Index 0 still returns 0.
- Undefined:
  - No comparators; reads return array contents only, as described under Behaviour.
  - The commit record is identical in both builds.

Test Plan:
- Assert reset for 1 cycle, then read all 32 indices on port A -> reg29=227, all others 0; wb_valid=0.
- reg_write=1, write_reg=8, write_data=0xDEADBEEF for 1 cycle; next cycle read_reg_a=8 -> read_data_a=0xDEADBEEF; wb_valid=1, wb_reg=8, wb_data=0xDEADBEEF; cycle after -> wb_valid=0.
- Write 0x12345678 to register 0, read both ports at 0 -> both 0; wb_valid stays 0.
- reset=1 and reg_write=1 (write_reg=29, write_data=5) in the same cycle -> reg29=227 afterwards, wb_valid=0.
- Same-cycle read and write of register 31 (old value 0x10, new value 0x400): bypass build -> read_data_a=0x400 in that cycle; non-bypass build -> 0x10, then 0x400 next cycle.
- Back-to-back writes to 3, 4 and 3 (values 1, 2, 3) on consecutive edges -> wb_valid high for 3 cycles with wb_reg sequence 3, 4, 3; final reg3=3 and reg4=2; read_reg_a=3 and read_reg_b=4 simultaneously -> 3 and 2.
